// File: rtl/cache_ctrl_wt.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_wt
// Description : Direct-mapped write-through cache controller with one
//               outstanding memory access and saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_wt #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  response,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  mem_req,
    output logic                  mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int c_IW = $clog2(NUM_LINES);
    localparam int c_TW = ADDR_WIDTH - c_IW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_RD = 2'd1,
        ST_MEM_WR = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [NUM_LINES-1:0]  r_valid;
    logic [c_TW-1:0]       r_tags  [NUM_LINES];
    logic [DATA_WIDTH-1:0] r_lines [NUM_LINES];
    logic [c_IW-1:0]       r_idx;
    logic [c_TW-1:0]       r_tag_q;

    logic [c_IW-1:0]       w_index;
    logic [c_TW-1:0]       w_tag;
    logic                  w_hit;
    logic                  w_rd_hit;
    logic                  w_rd_miss;
    logic                  w_wr;
    logic                  w_fill;
    logic                  w_wr_done;
    logic                  w_wr_update;

    assign w_index     = address[c_IW-1:0];
    assign w_tag       = address[ADDR_WIDTH-1:c_IW];
    assign w_hit       = r_valid[w_index] && (r_tags[w_index] == w_tag);
    // Write-through update uses the index/tag captured at acceptance
    assign w_wr_update = w_wr_done && r_valid[r_idx] && (r_tags[r_idx] == r_tag_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_hit     = 1'b0;
        w_rd_miss    = 1'b0;
        w_wr         = 1'b0;
        w_fill       = 1'b0;
        w_wr_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (mode) begin
                        w_wr         = 1'b1;
                        w_state_next = ST_MEM_WR;
                    end else if (w_hit) begin
                        w_rd_hit     = 1'b1;
                    end else begin
                        w_rd_miss    = 1'b1;
                        w_state_next = ST_MEM_RD;
                    end
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    w_fill       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    w_wr_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            busy        <= 1'b0;
            response    <= 1'b0;
            out         <= '0;
            mem_req     <= 1'b0;
            mem_mode    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            response <= 1'b0;
            if (w_rd_hit) begin
                out      <= r_lines[w_index];
                response <= 1'b1;
                if (hit_count != {CNT_WIDTH{1'b1}}) begin
                    hit_count <= hit_count + 1'b1;
                end
            end
            if (w_rd_miss || w_wr) begin
                mem_req     <= 1'b1;
                mem_mode    <= w_wr;
                mem_address <= address;
                busy        <= 1'b1;
            end
            if (w_wr) begin
                mem_data <= data;
            end
            if (w_rd_miss && (miss_count != {CNT_WIDTH{1'b1}})) begin
                miss_count <= miss_count + 1'b1;
            end
            if (w_fill) begin
                r_valid[r_idx] <= 1'b1;
                out            <= mem_rdata;
            end
            if (w_fill || w_wr_done) begin
                response <= 1'b1;
                mem_req  <= 1'b0;
                busy     <= 1'b0;
            end
        end
    end

    // Storage arrays and the acceptance latch carry no reset; valid bits gate them
    always_ff @(posedge clk) begin
        if (w_rd_miss || w_wr) begin
            r_idx   <= w_index;
            r_tag_q <= w_tag;
        end
        if (w_fill) begin
            r_lines[r_idx] <= mem_rdata;
            r_tags[r_idx]  <= r_tag_q;
        end else if (w_wr_update) begin
            r_lines[r_idx] <= mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_wt.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_wt
// Description : Directed self-checking bench for cache_ctrl_wt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_wt;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        mode;
    logic [31:0] address;
    logic [31:0] data;
    logic        busy;
    logic        response;
    logic [31:0] out;
    logic        mem_req;
    logic        mem_mode;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int errors = 0;
    int checks = 0;

    cache_ctrl_wt #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_LINES (4),
        .CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .mode       (mode),
        .address    (address),
        .data       (data),
        .busy       (busy),
        .response   (response),
        .out        (out),
        .mem_req    (mem_req),
        .mem_mode   (mem_mode),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; drive and sample 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_with(input logic [31:0] rdata);
        mem_ack = 1'b1; mem_rdata = rdata;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h want 0", busy); end
        checks++; if (response !== 1'b0) begin errors++; $display("FAIL rst_response: got %0h want 0", response); end
        checks++; if (mem_req !== 1'b0 || mem_mode !== 1'b0) begin errors++; $display("FAIL rst_mem_req_mode: got %0h/%0h want 0/0", mem_req, mem_mode); end
        checks++; if (out !== 32'h0 || mem_address !== 32'h0 || mem_data !== 32'h0) begin errors++; $display("FAIL rst_data: out=%0h addr=%0h mdata=%0h want 0", out, mem_address, mem_data); end
        checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin errors++; $display("FAIL rst_counters: got %0h/%0h want 0/0", hit_count, miss_count); end
        rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL post_rst_idle: busy=%0h mem_req=%0h want 0/0", busy, mem_req); end
    endtask

    task automatic test_read_miss();
        req_valid = 1'b1; mode = 1'b0; address = 32'h10;
        step();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_mode !== 1'b0) begin errors++; $display("FAIL miss_req: got req=%0h mode=%0h want 1/0", mem_req, mem_mode); end
        checks++; if (mem_address !== 32'h10) begin errors++; $display("FAIL miss_addr: got %0h want 10", mem_address); end
        checks++; if (busy !== 1'b1 || response !== 1'b0) begin errors++; $display("FAIL miss_busy: busy=%0h resp=%0h want 1/0", busy, response); end
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL miss_count1: got %0d want 1", miss_count); end
        address = 32'h3C;
        step(); step();
        checks++; if (mem_req !== 1'b1 || mem_address !== 32'h10) begin errors++; $display("FAIL miss_hold: req=%0h addr=%0h want 1/10", mem_req, mem_address); end
        ack_with(32'hDEADBEEF);
        checks++; if (response !== 1'b1 || out !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_resp: resp=%0h out=%0h want 1/deadbeef", response, out); end
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL miss_done: busy=%0h req=%0h want 0/0", busy, mem_req); end
        step();
        checks++; if (response !== 1'b0 || out !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_pulse: resp=%0h out=%0h want 0/deadbeef", response, out); end
    endtask

    task automatic test_read_hit();
        req_valid = 1'b1; mode = 1'b0; address = 32'h10;
        step();
        req_valid = 1'b0;
        checks++; if (response !== 1'b1 || out !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_resp: resp=%0h out=%0h want 1/deadbeef", response, out); end
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hit_nomem: req=%0h busy=%0h want 0/0", mem_req, busy); end
        checks++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin errors++; $display("FAIL hit_count1: got %0d/%0d want 1/1", hit_count, miss_count); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; mode = 1'b0; address = 32'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (response !== 1'b1) begin errors++; $display("FAIL b2b_resp%0d: got %0h want 1", i, response); end
        end
        req_valid = 1'b0;
        checks++; if (hit_count !== 16'd4) begin errors++; $display("FAIL b2b_hits: got %0d want 4", hit_count); end
        step();
        checks++; if (response !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0h want 0", response); end
    endtask

    task automatic test_write_hit();
        req_valid = 1'b1; mode = 1'b1; address = 32'h10; data = 32'h12345678;
        step();
        req_valid = 1'b0; data = 32'h0;
        checks++; if (mem_req !== 1'b1 || mem_mode !== 1'b1) begin errors++; $display("FAIL wr_req: req=%0h mode=%0h want 1/1", mem_req, mem_mode); end
        checks++; if (mem_data !== 32'h12345678 || mem_address !== 32'h10) begin errors++; $display("FAIL wr_bus: data=%0h addr=%0h want 12345678/10", mem_data, mem_address); end
        checks++; if (hit_count !== 16'd4 || miss_count !== 16'd1) begin errors++; $display("FAIL wr_counts: got %0d/%0d want 4/1", hit_count, miss_count); end
        step();
        ack_with(32'h0);
        checks++; if (response !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL wr_done: resp=%0h busy=%0h req=%0h want 1/0/0", response, busy, mem_req); end
        checks++; if (out !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_out_held: got %0h want deadbeef", out); end
        req_valid = 1'b1; mode = 1'b0; address = 32'h10;
        step();
        req_valid = 1'b0;
        checks++; if (response !== 1'b1 || out !== 32'h12345678 || mem_req !== 1'b0) begin errors++; $display("FAIL wr_readback: resp=%0h out=%0h req=%0h want 1/12345678/0", response, out, mem_req); end
        checks++; if (hit_count !== 16'd5) begin errors++; $display("FAIL wr_hits: got %0d want 5", hit_count); end
        step();
    endtask

    task automatic test_conflict();
        req_valid = 1'b1; mode = 1'b0; address = 32'h14;
        step();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_address !== 32'h14 || miss_count !== 16'd2) begin errors++; $display("FAIL cf_miss: req=%0h addr=%0h miss=%0d want 1/14/2", mem_req, mem_address, miss_count); end
        ack_with(32'hA5A5A5A5);
        checks++; if (response !== 1'b1 || out !== 32'hA5A5A5A5) begin errors++; $display("FAIL cf_fill: resp=%0h out=%0h want 1/a5a5a5a5", response, out); end
        req_valid = 1'b1; address = 32'h10;
        step();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_address !== 32'h10 || miss_count !== 16'd3) begin errors++; $display("FAIL cf_evict: req=%0h addr=%0h miss=%0d want 1/10/3", mem_req, mem_address, miss_count); end
        checks++; if (response !== 1'b0 || hit_count !== 16'd5) begin errors++; $display("FAIL cf_nohit: resp=%0h hits=%0d want 0/5", response, hit_count); end
        ack_with(32'h12345678);
        checks++; if (out !== 32'h12345678) begin errors++; $display("FAIL cf_refill: got %0h want 12345678", out); end
        step();
    endtask

    task automatic test_write_no_alloc();
        req_valid = 1'b1; mode = 1'b1; address = 32'h22; data = 32'h1;
        step();
        // A read hit of 0x10 held during busy must be ignored
        mode = 1'b0; address = 32'h10; data = 32'h0;
        step(); step();
        checks++; if (mem_mode !== 1'b1 || mem_address !== 32'h22 || mem_data !== 32'h1) begin errors++; $display("FAIL na_hold: mode=%0h addr=%0h data=%0h want 1/22/1", mem_mode, mem_address, mem_data); end
        checks++; if (response !== 1'b0 || hit_count !== 16'd5) begin errors++; $display("FAIL na_ignore: resp=%0h hits=%0d want 0/5", response, hit_count); end
        ack_with(32'h0);
        req_valid = 1'b0;
        checks++; if (response !== 1'b1 || hit_count !== 16'd5) begin errors++; $display("FAIL na_done: resp=%0h hits=%0d want 1/5", response, hit_count); end
        req_valid = 1'b1; mode = 1'b0; address = 32'h22;
        step();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_mode !== 1'b0 || mem_address !== 32'h22) begin errors++; $display("FAIL na_miss: req=%0h mode=%0h addr=%0h want 1/0/22", mem_req, mem_mode, mem_address); end
        checks++; if (miss_count !== 16'd4) begin errors++; $display("FAIL na_count: got %0d want 4", miss_count); end
        ack_with(32'h1);
        checks++; if (out !== 32'h1 || response !== 1'b1) begin errors++; $display("FAIL na_fill: out=%0h resp=%0h want 1/1", out, response); end
        step();
    endtask

    task automatic test_reset_mid_access();
        req_valid = 1'b1; mode = 1'b0; address = 32'h33;
        step();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || miss_count !== 16'd5) begin errors++; $display("FAIL rm_start: req=%0h miss=%0d want 1/5", mem_req, miss_count); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || response !== 1'b0) begin errors++; $display("FAIL rm_async: req=%0h busy=%0h resp=%0h want 0/0/0", mem_req, busy, response); end
        checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL rm_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
        step();
        rst = 1'b0;
        ack_with(32'hBAD0BAD0);
        checks++; if (response !== 1'b0 || busy !== 1'b0 || out !== 32'h0) begin errors++; $display("FAIL rm_late_ack: resp=%0h busy=%0h out=%0h want 0/0/0", response, busy, out); end
        req_valid = 1'b1; address = 32'h10;
        step();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_address !== 32'h10 || miss_count !== 16'd1 || hit_count !== 16'd0) begin errors++; $display("FAIL rm_remiss: req=%0h addr=%0h miss=%0d hit=%0d want 1/10/1/0", mem_req, mem_address, miss_count, hit_count); end
        ack_with(32'h12345678);
        checks++; if (response !== 1'b1 || out !== 32'h12345678) begin errors++; $display("FAIL rm_fill: resp=%0h out=%0h want 1/12345678", response, out); end
        step();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; mode = 1'b0; address = '0; data = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_back_to_back();
        test_write_hit();
        test_conflict();
        test_write_no_alloc();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_ctrl_wt.md
Name: cache_ctrl_wt

Overview:
- Parametrised direct-mapped, write-through cache controller in front of the `ram` model.
- Replaces the fixed read-via-cache / write-via-ram top level with one request/response port, a tag/valid store and a single-outstanding memory handshake.
- Adds hit/miss statistics counters.
- Sits between the test/CPU side and the RAM model.

Parameters:
- ADDR_WIDTH, 32, word address width.
- DATA_WIDTH, 32, data word width.
- NUM_LINES, 4, cache lines; power of two, >= 2; one word per line.
- CNT_WIDTH, 16, width of the hit/miss counters.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe; sampled only while busy=0.
- mode  in  1  0=read, 1=write.
- address  in  ADDR_WIDTH  request word address.
- data  in  DATA_WIDTH  write data.
- busy  out  1  high while a memory access is outstanding.
- response  out  1  one-cycle completion pulse.
- out  out  DATA_WIDTH  read data; valid when response=1; held until the next read completes.
- mem_req  out  1  memory request, held until acknowledged.
- mem_mode  out  1  0=read, 1=write.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_data  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- hit_count  out  CNT_WIDTH  accepted read hits, saturating.
- miss_count  out  CNT_WIDTH  accepted read misses, saturating.

Behaviour:
- Address split:
  - index = address[IW-1:0], with IW = log2(NUM_LINES).
  - tag = address[ADDR_WIDTH-1:IW].
  - hit = valid[index] && tag_store[index]==tag.
- Reset (async):
  - state=IDLE.
  - All valid bits cleared.
  - busy, response, mem_req, mem_mode = 0.
  - out, mem_address, mem_data, hit_count, miss_count = 0.
  - Tag/data arrays need no reset.
- Reset mid-access: mem_req drops immediately; the outstanding request is discarded and no response is issued. A later mem_ack is ignored because state=IDLE.
- FSM states: IDLE, MEM_RD, MEM_WR.
- IDLE, req_valid=1 (acceptance edge):
  - Read hit: out<=line data; response<=1 (visible the cycle after acceptance, latency 1); hit_count+1; stay IDLE. Back-to-back hits sustain one per cycle.
  - Read miss: mem_req<=1, mem_mode<=0, mem_address<=address; busy<=1; miss_count+1; go to MEM_RD.
  - Write, hit or miss: mem_req<=1, mem_mode<=1, mem_address<=address, mem_data<=data; busy<=1; go to MEM_WR. Counters are unchanged.
- MEM_RD:
  - mem_req, mem_address and mem_data stay stable until an edge with mem_ack=1.
  - On that edge: line[index] data<=mem_rdata, tag written, valid set; out<=mem_rdata; response<=1; mem_req<=0; busy<=0; go to IDLE.
- MEM_WR, on mem_ack:
  - If the line holds the same tag and is valid, its data<=mem_data (write-through update).
  - A write miss does not allocate.
  - response<=1; mem_req<=0; busy<=0; go to IDLE.
- response is high for exactly one cycle per accepted request. It is cleared on every edge where it is not being set.
- req_valid while busy=1 is ignored; requests are not queued, and the requester re-presents after busy falls.
- The request that completes on the mem_ack edge and a new request cannot share an edge, because busy is still 1 on that edge. The earliest new acceptance is the following edge.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- The index/tag used for the fill or update is latched at acceptance, not re-sampled from `address`.
- Counters saturate at all-ones with no wrap.
- A conflict miss overwrites the line; there is no write-back, because the cache is write-through.

Test Plan (ADDR_WIDTH=32, DATA_WIDTH=32, NUM_LINES=4):
- Reset, then read 0x10 → mem_req=1, mem_mode=0, mem_address=0x10 next cycle. Apply mem_ack with mem_rdata=0xDEADBEEF after 3 cycles → response pulse, out=0xDEADBEEF, busy=0, miss_count=1.
- Read 0x10 again → no mem_req; response one cycle after acceptance; out=0xDEADBEEF; hit_count=1. Three back-to-back reads of 0x10 → three consecutive response pulses, hit_count=4.
- Write 0x10 with 0x12345678 → mem_req with mem_mode=1, mem_data=0x12345678. On ack, response pulses. Next read of 0x10 hits with out=0x12345678 and no mem_req.
- Read 0x14 (same index 0, different tag) → miss, fill with 0xA5A5A5A5. Then read 0x10 → miss again, mem_address=0x10, miss_count increments.
- Write 0x22 (miss) with 0x1, then read 0x22 → the read misses (no write-allocate). req_valid held high during the write's busy period is not accepted.
- Assert rst in MEM_RD before ack → mem_req, busy, response=0 immediately, counters 0. Late mem_ack produces no response. Next read of 0x10 misses.
